// File: rtl/decimal_to_binary.sv
// rtl/decimal_to_binary.sv - sequential BCD-to-binary converter, one digit per clock, MSD first
module decimal_to_binary #(
   parameter int NUM_DIGITS = 8,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_WIDTH-1:0]    binary_out,
   output logic                    bad_digit,
   output logic                    overflow
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                  state;
   logic [4*NUM_DIGITS-1:0] bcd_r;
   logic [IDX_W-1:0]        idx;
   logic [OUT_WIDTH-1:0]    acc;
   logic                    bad_r;
   logic                    ovf_r;
   logic                    in_ready_r;
   logic                    out_valid_r;

   logic [3:0]              digit;
   logic [OUT_WIDTH+3:0]    step;

   // The latched word shifts left each step, so the current digit is always the top nibble.
   assign digit = bcd_r[4*NUM_DIGITS-1 -: 4];
   assign step  = {4'b0000, acc} * (OUT_WIDTH+4)'(10) + {{OUT_WIDTH{1'b0}}, digit};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_r       <= '0;
         idx         <= '0;
         acc         <= '0;
         bad_r       <= 1'b0;
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  bcd_r      <= bcd_in;
                  idx        <= IDX_W'(NUM_DIGITS - 1);
                  acc        <= '0;
                  bad_r      <= 1'b0;
                  ovf_r      <= 1'b0;
                  in_ready_r <= 1'b0;
                  state      <= CONV;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            CONV: begin
               acc   <= step[OUT_WIDTH-1:0];
               bcd_r <= bcd_r << 4;
               if (|step[OUT_WIDTH+3:OUT_WIDTH]) ovf_r <= 1'b1;
               if (digit > 4'd9)                 bad_r <= 1'b1;
               if (idx == '0) begin
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign binary_out = acc;
   assign bad_digit  = bad_r;
   assign overflow   = ovf_r;

endmodule

// File: tb/tb_decimal_to_binary.sv
// tb/tb_decimal_to_binary.sv - directed-vector bench for decimal_to_binary (8- and 10-digit builds)
module tb_decimal_to_binary;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        iv8 = 1'b0, or8 = 1'b0;
   logic [31:0] bcd8 = '0;
   logic        ir8, ov8, bad8, ovf8;
   logic [31:0] bin8;

   logic        iv10 = 1'b0, or10 = 1'b0;
   logic [39:0] bcd10 = '0;
   logic        ir10, ov10, bad10, ovf10;
   logic [31:0] bin10;

   bit          sel_wide = 1'b0;
   logic        rdy, ov, bad, ovf;
   logic [31:0] bin;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   decimal_to_binary #(.NUM_DIGITS(8), .OUT_WIDTH(32)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(ir8), .bcd_in(bcd8),
      .out_valid(ov8), .out_ready(or8), .binary_out(bin8),
      .bad_digit(bad8), .overflow(ovf8)
   );

   decimal_to_binary #(.NUM_DIGITS(10), .OUT_WIDTH(32)) dut10 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv10), .in_ready(ir10), .bcd_in(bcd10),
      .out_valid(ov10), .out_ready(or10), .binary_out(bin10),
      .bad_digit(bad10), .overflow(ovf10)
   );

   assign rdy = sel_wide ? ir10  : ir8;
   assign ov  = sel_wide ? ov10  : ov8;
   assign bin = sel_wide ? bin10 : bin8;
   assign bad = sel_wide ? bad10 : bad8;
   assign ovf = sel_wide ? ovf10 : ovf8;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic convert(input bit wide, input logic [39:0] bcd, input logic [31:0] exp_v,
                          input logic exp_bad, input logic exp_ovf, input string tag);
      int  w;
      int  lat;
      bit  rdy_low;
      sel_wide = wide;
      w = 0;
      while (!rdy && w < 20) begin tick(); w++; end
      check({tag, " ready"}, 64'(rdy), 64'd1);
      if (wide) begin bcd10 = bcd; iv10 = 1'b1; end
      else      begin bcd8 = bcd[31:0]; iv8 = 1'b1; end
      tick();
      iv8 = 1'b0; iv10 = 1'b0;
      lat = 0; rdy_low = 1'b1;
      while (!ov && lat < 30) begin
         if (rdy) rdy_low = 1'b0;
         tick();
         lat++;
      end
      if (rdy) rdy_low = 1'b0;
      check({tag, " latency"}, 64'(lat), wide ? 64'd10 : 64'd8);
      check({tag, " value"}, 64'(bin), 64'(exp_v));
      check({tag, " bad_digit"}, 64'(bad), 64'(exp_bad));
      check({tag, " overflow"}, 64'(ovf), 64'(exp_ovf));
      check({tag, " in_ready low"}, 64'(rdy_low), 64'd1);
      if (wide) or10 = 1'b1; else or8 = 1'b1;
      tick();
      or8 = 1'b0; or10 = 1'b0;
      check({tag, " out_valid drop"}, 64'(ov), 64'd0);
      check({tag, " ready after"}, 64'(rdy), 64'd1);
   endtask

   initial begin
      tick();
      tick();
      check("rst out_valid", 64'(ov8), 64'd0);
      check("rst binary_out", 64'(bin8), 64'd0);
      check("rst bad_digit", 64'(bad8), 64'd0);
      check("rst overflow", 64'(ovf8), 64'd0);
      check("rst in_ready", 64'(ir8), 64'd0);
      rst_n = 1'b1;
      tick();
      check("post-rst in_ready", 64'(ir8), 64'd1);

      convert(1'b0, 40'h12345678, 32'h00BC614E, 1'b0, 1'b0, "w12345678");
      convert(1'b0, 40'h99999999, 32'h05F5E0FF, 1'b0, 1'b0, "w99999999");
      convert(1'b0, 40'h00000000, 32'h00000000, 1'b0, 1'b0, "w0");
      convert(1'b0, 40'h0000000A, 32'd10,       1'b1, 1'b0, "wA");
      convert(1'b0, 40'h00000042, 32'd42,       1'b0, 1'b0, "w42");

      // Backpressure: hold out_ready low while a competing word is offered.
      sel_wide = 1'b0;
      bcd8 = 32'h00000255; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      for (int i = 0; i < 30 && !ov8; i++) tick();
      check("bp out_valid", 64'(ov8), 64'd1);
      bcd8 = 32'h00000999; iv8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp hold valid", 64'(ov8), 64'd1);
         check("bp hold value", 64'(bin8), 64'd255);
         check("bp hold in_ready", 64'(ir8), 64'd0);
      end
      iv8 = 1'b0; or8 = 1'b1;
      tick();
      or8 = 1'b0;
      check("bp release valid", 64'(ov8), 64'd0);
      check("bp release in_ready", 64'(ir8), 64'd1);
      for (int i = 0; i < 12; i++) tick();
      check("bp no stray word", 64'(ov8), 64'd0);
      check("bp still idle", 64'(ir8), 64'd1);

      // Reset three cycles into a conversion.
      bcd8 = 32'h87654321; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst out_valid", 64'(ov8), 64'd0);
      check("midrst binary_out", 64'(bin8), 64'd0);
      check("midrst bad_digit", 64'(bad8), 64'd0);
      check("midrst overflow", 64'(ovf8), 64'd0);
      tick();
      check("midrst in_ready", 64'(ir8), 64'd1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 12; i++) begin tick(); if (ov8) seen = 1'b1; end
         check("midrst no out_valid", 64'(seen), 64'd0);
      end
      convert(1'b0, 40'h00000007, 32'd7, 1'b0, 1'b0, "w7");

      convert(1'b1, 40'h4294967296, 32'h00000000, 1'b0, 1'b1, "w10 2^32");
      convert(1'b1, 40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0, "w10 max");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
